// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: in-flight rd scoreboard with operand forwarding, load-use stall, flush and stall counter
module pipeline_hazard_unit #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dec_valid,
  input  logic [RA_W-1:0]            dec_rs1,
  input  logic [RA_W-1:0]            dec_rs2,
  input  logic                       dec_rs1_rd,
  input  logic                       dec_rs2_rd,
  input  logic [RA_W-1:0]            dec_rd,
  input  logic                       dec_rd_wr,
  input  logic [XLEN-1:0]            rf_a,
  input  logic [XLEN-1:0]            rf_b,
  input  logic [DEPTH*XLEN-1:0]      stg_res,
  input  logic [DEPTH-1:0]           stg_res_vld,
  input  logic                       mem_busy,
  input  logic                       br_flush,
  output logic [XLEN-1:0]            opnd_a,
  output logic [XLEN-1:0]            opnd_b,
  output logic [$clog2(DEPTH+1)-1:0] sel_a,
  output logic [$clog2(DEPTH+1)-1:0] sel_b,
  output logic                       stall,
  output logic                       issue,
  output logic [CNT_W-1:0]           stall_cycles
);
  localparam int SEL_W = $clog2(DEPTH+1);
  localparam int NS    = 2**SEL_W;
  logic [DEPTH:1]   r_vld;
  logic [RA_W-1:0]  r_rd [1:DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  w_stg [NS];
  logic [NS-1:0]    w_rv;
  logic [SEL_W-1:0] w_win_a, w_win_b;
  logic             w_hz_a, w_hz_b;
  // Index 0 and any padding slots above DEPTH are never selected; the writeback stage is always final
  for (genvar s = 0; s < NS; s++) begin : g_stg
    if (s >= 1 && s <= DEPTH) begin : g_real
      assign w_stg[s] = stg_res[(s-1)*XLEN +: XLEN];
      assign w_rv[s]  = (s == DEPTH) || stg_res_vld[s-1];
    end else begin : g_pad
      assign w_stg[s] = '0;
      assign w_rv[s]  = 1'b1;
    end
  end
  // Youngest in-flight writer of rs (lowest stage number), 0 when none; x0 never matches
  function automatic logic [SEL_W-1:0] youngest(input logic [RA_W-1:0] rs, input logic en);
    youngest = '0;
    for (int k = DEPTH; k >= 1; k--)
      if (en && rs != '0 && r_vld[k] && r_rd[k] == rs) youngest = SEL_W'(k);
  endfunction
  // Operand selection and hazard detection, purely combinational from decode
  always_comb begin
    w_win_a = youngest(dec_rs1, dec_rs1_rd);
    w_win_b = youngest(dec_rs2, dec_rs2_rd);
    w_hz_a  = (w_win_a != '0) && (FWD_EN == 0 || !w_rv[w_win_a]);
    w_hz_b  = (w_win_b != '0) && (FWD_EN == 0 || !w_rv[w_win_b]);
    sel_a   = (w_win_a != '0 && !w_hz_a) ? w_win_a : '0;
    sel_b   = (w_win_b != '0 && !w_hz_b) ? w_win_b : '0;
    opnd_a  = (sel_a == '0) ? rf_a : w_stg[sel_a];
    opnd_b  = (sel_b == '0) ? rf_b : w_stg[sel_b];
    stall   = mem_busy | (dec_valid & (w_hz_a | w_hz_b));
    issue   = dec_valid & ~stall & ~br_flush;
  end
  // Scoreboard: frozen while memory is busy, cleared by a flush, otherwise shifts one stage per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 1; k <= DEPTH; k++) r_rd[k] <= '0;
    end else if (!mem_busy) begin
      if (br_flush) r_vld <= '0;
      else begin
        r_vld   <= {r_vld[DEPTH-1:1], issue & dec_rd_wr & (dec_rd != '0)};
        r_rd[1] <= dec_rd;
        for (int k = 2; k <= DEPTH; k++) r_rd[k] <= r_rd[k-1];
      end
    end
  end
  // Saturating count of hazard stalls seen by a valid decode while memory is ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (dec_valid & stall & ~mem_busy & ~&r_cnt) r_cnt <= r_cnt + 1'b1;
  end
  assign stall_cycles = r_cnt;
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: three hazard units (forwarding, no forwarding, 4-bit counter) against a reference model
module tb_pipeline_hazard_unit;
  logic        clk, rst_n;
  logic        dec_valid, dec_rs1_rd, dec_rs2_rd, dec_rd_wr, mem_busy, br_flush;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] rf_a, rf_b;
  logic [95:0] stg_res;
  logic [2:0]  stg_res_vld;
  logic [2:0]  d_st, d_is;
  logic [1:0]  d_sa [3];
  logic [1:0]  d_sb [3];
  logic [31:0] d_oa [3];
  logic [31:0] d_ob [3];
  logic [15:0] d_cnt [3];
  logic [3:0]  c4;
  int n_cmp = 0, n_bad = 0;
  int fwd  [3] = '{1, 0, 1};
  int cmax [3] = '{65535, 65535, 15};
  logic       m_vld [3][4];
  logic [4:0] m_rd  [3][4];
  int         m_cnt [3];

  pipeline_hazard_unit #(.DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_f (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_rd(dec_rs1_rd), .dec_rs2_rd(dec_rs2_rd), .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr),
    .rf_a(rf_a), .rf_b(rf_b), .stg_res(stg_res), .stg_res_vld(stg_res_vld), .mem_busy(mem_busy),
    .br_flush(br_flush), .opnd_a(d_oa[0]), .opnd_b(d_ob[0]), .sel_a(d_sa[0]), .sel_b(d_sb[0]),
    .stall(d_st[0]), .issue(d_is[0]), .stall_cycles(d_cnt[0]));
  pipeline_hazard_unit #(.DEPTH(3), .FWD_EN(0), .CNT_W(16)) u_n (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_rd(dec_rs1_rd), .dec_rs2_rd(dec_rs2_rd), .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr),
    .rf_a(rf_a), .rf_b(rf_b), .stg_res(stg_res), .stg_res_vld(stg_res_vld), .mem_busy(mem_busy),
    .br_flush(br_flush), .opnd_a(d_oa[1]), .opnd_b(d_ob[1]), .sel_a(d_sa[1]), .sel_b(d_sb[1]),
    .stall(d_st[1]), .issue(d_is[1]), .stall_cycles(d_cnt[1]));
  pipeline_hazard_unit #(.DEPTH(3), .FWD_EN(1), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_rd(dec_rs1_rd), .dec_rs2_rd(dec_rs2_rd), .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr),
    .rf_a(rf_a), .rf_b(rf_b), .stg_res(stg_res), .stg_res_vld(stg_res_vld), .mem_busy(mem_busy),
    .br_flush(br_flush), .opnd_a(d_oa[2]), .opnd_b(d_ob[2]), .sel_a(d_sa[2]), .sel_b(d_sb[2]),
    .stall(d_st[2]), .issue(d_is[2]), .stall_cycles(c4));
  assign d_cnt[2] = {12'b0, c4};

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Operand resolution straight from the rules: youngest matching producer, forward if final, else hazard
  function automatic void pick(input int i, input logic [4:0] rs, input logic en, input logic [31:0] rf,
                               output logic hz, output logic [1:0] sel, output logic [31:0] val);
    int w = 0;
    hz = 0; sel = 0; val = rf;
    for (int k = 3; k >= 1; k--) if (en && rs != 0 && m_vld[i][k] && m_rd[i][k] == rs) w = k;
    if (w != 0) begin
      if (fwd[i] == 0 || (w < 3 && !stg_res_vld[w-1])) hz = 1;
      else begin sel = 2'(w); val = stg_res[w*32-1 -: 32]; end
    end
  endfunction

  function automatic void model_out(input int i, output logic st, output logic iss,
                                    output logic [1:0] sa, output logic [1:0] sb,
                                    output logic [31:0] oa, output logic [31:0] ob);
    logic ha, hb;
    pick(i, dec_rs1, dec_rs1_rd, rf_a, ha, sa, oa);
    pick(i, dec_rs2, dec_rs2_rd, rf_b, hb, sb, ob);
    st  = mem_busy | (dec_valid & (ha | hb));
    iss = dec_valid & !st & !br_flush;
  endfunction

  initial for (int i = 0; i < 3; i++) begin
    m_cnt[i] = 0;
    for (int k = 0; k < 4; k++) begin m_vld[i][k] = 0; m_rd[i][k] = 0; end
  end

  always @(posedge clk or negedge rst_n) begin
    logic st, iss;
    logic [1:0] sa, sb;
    logic [31:0] oa, ob;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_cnt[i] = 0;
        for (int k = 1; k <= 3; k++) m_vld[i][k] = 0;
      end else begin
        model_out(i, st, iss, sa, sb, oa, ob);
        if (dec_valid && st && !mem_busy && m_cnt[i] < cmax[i]) m_cnt[i]++;
        if (!mem_busy) begin
          if (br_flush) for (int k = 1; k <= 3; k++) m_vld[i][k] = 0;
          else begin
            for (int k = 3; k >= 2; k--) begin m_vld[i][k] = m_vld[i][k-1]; m_rd[i][k] = m_rd[i][k-1]; end
            m_vld[i][1] = iss && dec_rd_wr && dec_rd != 0;
            m_rd[i][1]  = dec_rd;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic st, iss;
    logic [1:0] sa, sb;
    logic [31:0] oa, ob;
    for (int i = 0; i < 3; i++) begin
      model_out(i, st, iss, sa, sb, oa, ob);
      chk($sformatf("u%0d stall", i), d_st[i], st);
      chk($sformatf("u%0d issue", i), d_is[i], iss);
      chk($sformatf("u%0d sel_a", i), d_sa[i], sa);
      chk($sformatf("u%0d sel_b", i), d_sb[i], sb);
      chk($sformatf("u%0d opnd_a", i), d_oa[i], oa);
      chk($sformatf("u%0d opnd_b", i), d_ob[i], ob);
      chk($sformatf("u%0d stall_cycles", i), d_cnt[i], 64'(m_cnt[i]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 0; dec_valid = 0; mem_busy = 0; br_flush = 0;
    #2;
    rst_n = 1;
  endtask

  task automatic drv(input logic v, input logic [4:0] r1, input logic e1, input logic [4:0] r2,
                     input logic e2, input logic [4:0] rd, input logic w);
    dec_valid = v; dec_rs1 = r1; dec_rs1_rd = e1; dec_rs2 = r2; dec_rs2_rd = e2; dec_rd = rd; dec_rd_wr = w;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; mem_busy = 0; br_flush = 0;
    rf_a = 32'h11; rf_b = 32'h22;
    stg_res = {32'h33, 32'h77, 32'h42};
    stg_res_vld = 3'b000;
    drv(0, 5'd1, 1, 5'd2, 1, 5'd3, 1);
    #1;
    chk("reset issue", d_is[0], 0);
    chk("reset stall", d_st[0], 0);
    chk("reset opnd_a", d_oa[0], 32'h11);
    chk("reset sel_b", d_sb[0], 0);
    chk("reset cnt", d_cnt[0], 0);
    mem_busy = 1;
    #1;
    chk("reset stall=mem_busy", d_st[0], 1);
    mem_busy = 0;
    #10;
    rst_n = 1;
    // forwarding from s1
    step();
    drv(1, 5'd1, 1, 5'd2, 1, 5'd5, 1);
    #1 chk("fwd producer issue", d_is[0], 1);
    step();
    drv(1, 5'd5, 1, 5'd0, 1, 5'd6, 1);
    stg_res_vld = 3'b001;
    #1;
    chk("fwd stall", d_st[0], 0);
    chk("fwd sel_a", d_sa[0], 1);
    chk("fwd opnd_a", d_oa[0], 32'h42);
    chk("fwd x0 sel_b", d_sb[0], 0);
    chk("fwd x0 opnd_b", d_ob[0], 32'h22);
    chk("nofwd stall", d_st[1], 1);
    step();
    // load-use
    rst_pulse();
    stg_res_vld = 3'b000;
    drv(1, 5'd0, 0, 5'd0, 0, 5'd5, 1);
    step();
    drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 1);
    #1;
    chk("load-use stall", d_st[0], 1);
    chk("load-use issue", d_is[0], 0);
    step();
    stg_res_vld = 3'b010;
    #1;
    chk("load-use stall2", d_st[0], 0);
    chk("load-use sel_a", d_sa[0], 2);
    chk("load-use opnd_a", d_oa[0], 32'h77);
    chk("load-use cnt", d_cnt[0], 1);
    step();
    // no forwarding: three stall cycles
    rst_pulse();
    stg_res_vld = 3'b111;
    drv(1, 5'd1, 1, 5'd2, 1, 5'd7, 1);
    step();
    drv(1, 5'd7, 1, 5'd0, 0, 5'd8, 1);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("nofwd stall c%0d", c), d_st[1], 1);
      step();
    end
    #1;
    chk("nofwd stall done", d_st[1], 0);
    chk("nofwd sel_a", d_sa[1], 0);
    chk("nofwd opnd_a", d_oa[1], 32'h11);
    chk("nofwd cnt", d_cnt[1], 3);
    step();
    // x0 writer never creates a hazard
    rst_pulse();
    stg_res_vld = 3'b000;
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 1);
    step();
    drv(1, 5'd0, 1, 5'd0, 1, 5'd4, 1);
    #1;
    chk("x0 stall fwd", d_st[0], 0);
    chk("x0 stall nofwd", d_st[1], 0);
    chk("x0 sel_a", d_sa[0], 0);
    step();
    // flush, with and without memory freeze
    rst_pulse();
    for (int k = 1; k <= 3; k++) begin
      drv(1, 5'd0, 0, 5'd0, 0, 5'(k), 1);
      step();
    end
    mem_busy = 1; br_flush = 1;
    drv(1, 5'd3, 1, 5'd0, 0, 5'd9, 1);
    #1;
    chk("busy+flush stall", d_st[0], 1);
    chk("busy+flush issue", d_is[0], 0);
    step();
    mem_busy = 0;
    stg_res_vld = 3'b111;
    drv(1, 5'd3, 1, 5'd1, 1, 5'd9, 1);
    #1;
    chk("flush stall", d_st[0], 0);
    chk("flush issue", d_is[0], 0);
    chk("frozen sel_a", d_sa[0], 1);
    chk("frozen sel_b", d_sb[0], 3);
    chk("frozen opnd_b", d_ob[0], 32'h33);
    step();
    br_flush = 0;
    drv(1, 5'd3, 1, 5'd2, 1, 5'd9, 1);
    #1;
    chk("flushed sel_a", d_sa[0], 0);
    chk("flushed sel_b", d_sb[0], 0);
    chk("flushed issue", d_is[0], 1);
    step();
    // memory freeze with hazard, then reset mid-freeze
    rst_pulse();
    stg_res_vld = 3'b000;
    drv(1, 5'd0, 0, 5'd0, 0, 5'd5, 1);
    step();
    drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 1);
    #1 chk("freeze pre stall", d_st[0], 1);
    step();
    mem_busy = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("freeze stall c%0d", c), d_st[0], 1);
      chk($sformatf("freeze cnt c%0d", c), d_cnt[0], 1);
      step();
    end
    chk("freeze cnt end", d_cnt[0], 1);
    rst_n = 0;
    #1 chk("async rst cnt", d_cnt[0], 0);
    mem_busy = 0;
    #1;
    chk("async rst stall", d_st[0], 0);
    chk("async rst sel_a", d_sa[0], 0);
    chk("async rst issue", d_is[0], 1);
    rst_n = 1;
    step();
    // counter saturation under a repeating load-use chain
    rst_pulse();
    stg_res_vld = 3'b000;
    drv(1, 5'd5, 1, 5'd0, 0, 5'd5, 1);
    repeat (40) step();
    chk("sat cnt fwd", d_cnt[0], 26);
    chk("sat cnt nofwd", d_cnt[1], 30);
    chk("sat cnt 4bit", d_cnt[2], 15);
    drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
